// File: rtl/ysyx_23060096_rf_wb_arbiter_pkg.sv
// Shared defaults, constants and types for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_NUM_REQ    = 2;

  localparam int unsigned REG_ZERO = 0;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/ysyx_23060096_rf_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ flattened valid/ready/addr/data lanes, lane i in slice i.
interface ysyx_23060096_rf_wb_arbiter_if
  import rf_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/ysyx_23060096_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer advances on accept.
module ysyx_23060096_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] gnt_idx;

  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    gnt_o   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = PtrW'((32'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard and registered write outputs.
// Optional checker enabled by YSYX_23060096_RF_WB_CHECK_EN adds a sticky wb_err output.
module ysyx_23060096_rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_23060096_rf_wb_arbiter_if.slave wb,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  alloc_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef YSYX_23060096_RF_WB_CHECK_EN
  ,
  output logic                  wb_err
`endif
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] Zero = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REQ-1:0]    gnt;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NumRegs-1:0]    pending_q, pending_d;

  ysyx_23060096_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .req_i    (wb.req_valid),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign wb.req_ready = gnt;
  assign accept       = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 writes are consumed but never reach the register file.
  always_comb begin
    rf_wen_d   = accept && (sel_addr != Zero);
    rf_waddr_d = accept ? sel_addr : rf_waddr_q;
    rf_wdata_d = accept ? sel_data : rf_wdata_q;
  end

  // The write on rf_* commits this cycle, so it bypasses both the WAW stall and operand busy.
  always_comb begin
    alloc_ready = !pending_q[alloc_addr] || (rf_wen_q && (rf_waddr_q == alloc_addr));
    rs1_busy    = pending_q[rs1_addr] && !(rf_wen_q && (rf_waddr_q == rs1_addr));
    rs2_busy    = pending_q[rs2_addr] && !(rf_wen_q && (rf_waddr_q == rs2_addr));
  end

  // Clear before set so a same-cycle reallocation keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (alloc_valid && alloc_ready && (alloc_addr != Zero)) begin
      pending_d[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef YSYX_23060096_RF_WB_CHECK_EN
  logic wb_err_q, wb_err_d;
  logic dup_addr, wb_stray;

  always_comb begin
    dup_addr = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = i + 1; j < NUM_REQ; j++) begin
        if (wb.req_valid[i] && wb.req_valid[j] &&
            (wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wb.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH]) &&
            (wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != Zero)) begin
          dup_addr = 1'b1;
        end
      end
    end
    wb_stray = rf_wen_q && !pending_q[rf_waddr_q];
    wb_err_d = wb_err_q || dup_addr || wb_stray;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_stray) begin
      $error("rf_wb_arbiter: writeback to non-pending x%0d", rf_waddr_q);
    end
    if (!rst && dup_addr) begin
      $error("rf_wb_arbiter: two requesters target the same register");
    end
  end

  assign wb_err = wb_err_q;
`endif

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Directed plus randomized bench for the register-file writeback arbiter against a queue-free
// behavioural model (pending set, rotating priority, one-cycle write pipe).
module tb_ysyx_23060096_rf_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0] s_valid;
  logic [AW-1:0] s_addr [NR];
  logic [DW-1:0] s_data [NR];
  logic          alloc_valid;
  logic [AW-1:0] alloc_addr, rs1_addr, rs2_addr;
  logic          alloc_ready, rs1_busy, rs2_busy, rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef YSYX_23060096_RF_WB_CHECK_EN
  logic          wb_err;
`endif

  ysyx_23060096_rf_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

  always_comb begin
    wb_if.req_valid = s_valid;
    wb_if.req_addr  = '0;
    wb_if.req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      wb_if.req_addr[i*AW +: AW] = s_addr[i];
      wb_if.req_data[i*DW +: DW] = s_data[i];
    end
  end

  ysyx_23060096_rf_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb_if.slave),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
`ifdef YSYX_23060096_RF_WB_CHECK_EN
    ,
    .wb_err      (wb_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  int          m_ptr = 0;
  bit [31:0]   m_pend = '0;
  bit          m_wen = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit          m_err = 1'b0;

  function automatic bit m_bypass(input logic [AW-1:0] a);
    return m_wen && (m_waddr == a);
  endfunction

  // Compare every cycle at the falling edge, then advance the model across the next rising edge.
  initial forever begin
    @(negedge clk);
    begin
      int            g;
      logic [NR-1:0] er;
      bit            ear, eb1, eb2, dup;
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (g < 0 && s_valid[idx]) g = idx;
      end
      er  = (g >= 0) ? NR'(1 << g) : '0;
      ear = !m_pend[alloc_addr] || m_bypass(alloc_addr);
      eb1 = m_pend[rs1_addr] && !m_bypass(rs1_addr);
      eb2 = m_pend[rs2_addr] && !m_bypass(rs2_addr);
      dup = 1'b0;
      for (int i = 0; i < NR; i++)
        for (int j = i + 1; j < NR; j++)
          if (s_valid[i] && s_valid[j] && s_addr[i] == s_addr[j] && s_addr[i] != 0) dup = 1'b1;
      if (chk_en) begin
        chk("req_ready", 64'(wb_if.req_ready), 64'(er));
        chk("alloc_ready", 64'(alloc_ready), 64'(ear));
        chk("rs1_busy", 64'(rs1_busy), 64'(eb1));
        chk("rs2_busy", 64'(rs2_busy), 64'(eb2));
        chk("rf_wen", 64'(rf_wen), 64'(m_wen));
        if (m_wen) begin
          chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
          chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        end
`ifdef YSYX_23060096_RF_WB_CHECK_EN
        chk("wb_err", 64'(wb_err), 64'(m_err));
`endif
      end
      if (rst) begin
        m_ptr = 0; m_pend = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
      end else begin
        m_err = m_err || (m_wen && !m_pend[m_waddr]) || dup;
        if (m_wen) m_pend[m_waddr] = 1'b0;
        if (alloc_valid && ear && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
        if (g >= 0) begin
          m_wen   = (s_addr[g] != 0);
          m_waddr = s_addr[g];
          m_wdata = s_data[g];
          m_ptr   = (g + 1) % NR;
        end else begin
          m_wen = 1'b0;
        end
      end
    end
  end

  task automatic idle();
    s_valid = '0;
    for (int i = 0; i < NR; i++) begin
      s_addr[i] = '0;
      s_data[i] = '0;
    end
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    rst         = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    next();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Idle after reset.
    settle();
    chk("reset_wen", 64'(rf_wen), 64'd0);
    chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("reset_busy", 64'({rs1_busy, rs2_busy}), 64'd0);
    next();

    idle(); alloc_valid = 1'b1; alloc_addr = 5;
    settle(); chk("alloc5_ready", 64'(alloc_ready), 64'd1);
    next();
    idle(); rs1_addr = 5;
    settle(); chk("x5_busy", 64'(rs1_busy), 64'd1);
    next();

    // Requester 1 writes x5.
    idle(); s_valid = 2'b10; s_addr[1] = 5; s_data[1] = 32'hDEADBEEF; rs1_addr = 5;
    settle();
    chk("wr5_ready", 64'(wb_if.req_ready), 64'b10);
    chk("wr5_busy_before", 64'(rs1_busy), 64'd1);
    next();
    idle(); rs1_addr = 5;
    settle();
    chk("wr5_wen", 64'(rf_wen), 64'd1);
    chk("wr5_waddr", 64'(rf_waddr), 64'd5);
    chk("wr5_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    chk("wr5_bypass", 64'(rs1_busy), 64'd0);
    next();
    idle(); rs1_addr = 5;
    settle();
    chk("wr5_cleared", 64'(rs1_busy), 64'd0);
    chk("wr5_wen_off", 64'(rf_wen), 64'd0);
    next();

    // Both requesters contend for four cycles.
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 4) begin
        s_valid = 2'b11; s_addr[0] = 3; s_addr[1] = 4; s_data[0] = c; s_data[1] = 100 + c;
      end
      settle();
      if (c < 4) chk("rr_grant", 64'(wb_if.req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
      if (c > 0) begin
        chk("rr_wen", 64'(rf_wen), 64'd1);
        chk("rr_waddr", 64'(rf_waddr), ((c - 1) % 2 == 0) ? 64'd3 : 64'd4);
      end
      next();
    end

    // Write to x0 is accepted but produces no register write.
    idle(); s_valid = 2'b01; s_addr[0] = 0; s_data[0] = 32'h1234;
    settle(); chk("x0_ready", 64'(wb_if.req_ready), 64'b01);
    next();
    idle();
    settle(); chk("x0_wen", 64'(rf_wen), 64'd0);
    next();

    // WAW stall on x7, then allocation in the same cycle as its writeback.
    idle(); alloc_valid = 1'b1; alloc_addr = 7;
    settle(); chk("alloc7_first", 64'(alloc_ready), 64'd1);
    next();
    idle(); alloc_valid = 1'b1; alloc_addr = 7; s_valid = 2'b01; s_addr[0] = 7; s_data[0] = 77;
    settle();
    chk("alloc7_stall", 64'(alloc_ready), 64'd0);
    chk("wr7_ready", 64'(wb_if.req_ready), 64'b01);
    next();
    idle(); alloc_valid = 1'b1; alloc_addr = 7;
    settle();
    chk("wr7_wen", 64'(rf_wen), 64'd1);
    chk("alloc7_bypass", 64'(alloc_ready), 64'd1);
    next();
    idle(); rs2_addr = 7;
    settle(); chk("x7_still_pending", 64'(rs2_busy), 64'd1);
    next();

    // Reset in the middle of allocations and an in-flight write.
    idle(); alloc_valid = 1'b1; alloc_addr = 10; s_valid = 2'b01; s_addr[0] = 12; s_data[0] = 1;
    next();
    idle(); alloc_valid = 1'b1; alloc_addr = 11; s_valid = 2'b01; s_addr[0] = 13; rst = 1'b1;
    next();
    idle(); s_valid = 2'b11; s_addr[0] = 1; s_addr[1] = 2; rs1_addr = 10; rs2_addr = 11;
    settle();
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_busy", 64'({rs1_busy, rs2_busy}), 64'd0);
    chk("rst_ptr", 64'(wb_if.req_ready), 64'b01);
    next();

`ifdef YSYX_23060096_RF_WB_CHECK_EN
    idle(); s_valid = 2'b01; s_addr[0] = 9;
    next();
    idle();
    next();
    idle();
    settle(); chk("wb_err_set", 64'(wb_err), 64'd1);
    next();
    next();
    settle(); chk("wb_err_sticky", 64'(wb_err), 64'd1);
    next();
`endif

    // Randomized traffic on a small register window to force hazards.
    for (int n = 0; n < 3000; n++) begin
      s_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        s_addr[i] = AW'($urandom_range(0, 7));
        s_data[i] = $urandom;
      end
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_addr  = AW'($urandom_range(0, 7));
      rs1_addr    = AW'($urandom_range(0, 7));
      rs2_addr    = AW'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 199) == 0);
      next();
    end
    idle();
    settle();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060096_rf_wb_arbiter.md
Name: ysyx_23060096_rf_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback requesters (e.g. ALU result, LSU load return) using round-robin arbitration with valid/ready handshakes.
- Keeps a pending-write scoreboard: decode allocates a destination register, the matching writeback clears it, and busy flags tell decode when an operand must stall.
- Sits between the execute/LSU writeback paths and ysyx_23060096_RegisterFile.
- Drives that block's w_en/waddr/wdata from registered outputs.

Parameters:
- ADDR_WIDTH, 5, register index width; 1<<ADDR_WIDTH architectural registers.
- DATA_WIDTH, 32, register data width.
- NUM_REQ, 2, number of writeback requesters (2..4). Index 0 has highest initial priority.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester writeback valid.
- req_ready  out  NUM_REQ  per-requester grant; combinational, one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_WIDTH  destination index, requester i in slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  write data, requester i in slice i.
- alloc_valid  in  1  decode wants to mark alloc_addr pending.
- alloc_addr  in  ADDR_WIDTH  destination being allocated.
- alloc_ready  out  1  allocation accepted this cycle.
- rs1_addr  in  ADDR_WIDTH  decode operand 1 index.
- rs2_addr  in  ADDR_WIDTH  decode operand 2 index.
- rs1_busy  out  1  operand 1 has an outstanding write.
- rs2_busy  out  1  operand 2 has an outstanding write.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register-file write index (registered).
- rf_wdata  out  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset (synchronous on rst high):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - Scoreboard all 0.
  - Round-robin pointer = 0.
  - rst mid-operation drops any registered write not yet presented and clears all pending bits.
- Arbitration:
  - Grant goes to the first valid requester at or after the pointer, in index order with wrap.
  - req_ready[i]=1 only for the granted index.
  - Every cycle can accept one request; there is no backpressure from the register file.
  - On accept, the pointer moves to granted index +1, mod NUM_REQ. With no accept, the pointer holds.
- Latency:
  - An accepted request at cycle N appears on rf_wen/rf_waddr/rf_wdata at cycle N+1.
  - rf_wen is 0 in any cycle following a non-accept cycle.
- x0 handling:
  - A request with addr 0 is accepted normally but produces rf_wen=0.
  - It leaves the scoreboard unchanged.
  - alloc of addr 0 is always accepted and never sets a bit.
  - rs*_busy for addr 0 is always 0.
- Scoreboard:
  - One bit per register.
  - Set on alloc handshake (alloc_valid && alloc_ready).
  - Cleared in the cycle rf_wen=1 for rf_waddr.
- alloc_ready:
  - alloc_ready = !pending[alloc_addr], i.e. WAW allocations stall.
  - Exception: alloc_ready is also 1 when rf_wen && rf_waddr==alloc_addr in the same cycle. In that case set wins and the bit stays 1.
- Busy/bypass:
  - rsX_busy = pending[rsX_addr] && !(rf_wen && rf_waddr==rsX_addr).
  - The register file commits the write within that cycle, so decode may read it in the same cycle.
- Writeback to a non-pending nonzero addr: written to the register file; scoreboard unchanged.

Optional Feature:
- Macro: YSYX_23060096_RF_WB_CHECK_EN.
- When defined:
  - Adds output port wb_err (1 bit, sticky, reset 0).
  - wb_err is set when rf_wen=1 with nonzero rf_waddr whose pending bit is 0, or when two requesters present the same nonzero addr in one cycle.
  - Adds simulation $error on either event.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rf_wb_pkg holds:
  - Default ADDR_WIDTH/DATA_WIDTH/NUM_REQ.
  - Constant REG_ZERO=0.
  - typedefs reg_idx_t (ADDR_WIDTH bits) and reg_data_t (DATA_WIDTH bits).
- Sub-module ysyx_23060096_rr_arbiter (NUM_REQ-wide request vector -> one-hot grant, with pointer register and update-on-accept input) is instantiated once.
- Scoreboard and output registers stay in the top module.

Test Plan:
- Reset, then idle:
  - rf_wen=0, all busy=0, alloc_ready=1.
  - Alloc x5 then query rs1=5: rs1_busy=1.
- Alloc x5; requester 1 writes x5=0xDEADBEEF at cycle N:
  - Cycle N+1: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rs1_busy(5)=0.
  - Cycle N+2: rs1_busy=0, pending cleared.
- Both requesters valid for 4 cycles, addrs 3 and 4: grants alternate 0,1,0,1 and rf_waddr sequence is 3,4,3,4.
- Requester 0 writes x0=0x1234: req_ready[0]=1, next cycle rf_wen=0, scoreboard unchanged.
- x7 pending, alloc x7 without writeback: alloc_ready=0.
  - Same alloc in the cycle rf_wen writes x7: alloc_ready=1, and x7 stays pending afterwards.
- Two allocs and a request in flight, assert rst one cycle:
  - Next cycle rf_wen=0, all busy=0, pointer=0.
  - With CHECK_EN, a writeback to non-pending x9 sets wb_err=1 and it stays set until rst.
